// File: rtl/host_if_pkg.sv
// Shared definitions for the S1D13700 host-port master: state encoding,
// protocol mode selectors, default timing and the phase-counter width helper.
package host_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV
  } state_t;

  localparam int MODE_8080 = 0;
  localparam int MODE_6800 = 1;

  localparam int DEF_T_SU  = 1;
  localparam int DEF_T_PW  = 5;
  localparam int DEF_T_HD  = 1;
  localparam int DEF_T_REC = 5;

  // Width needed to hold the largest phase length minus one.
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/host_phase_cnt.sv
// Loadable down-counter that times each bus phase; it stops at zero
// rather than wrapping, so an unloaded counter sits idle at zero.
module host_phase_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_x,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/host_bus_master.sv
// S1D13700 parallel host-port master: turns single command/data requests into
// timed 8080 or 6800 bus cycles with registered pins and read-data capture.
module host_bus_master
  import host_if_pkg::*;
#(
  parameter int DW    = 8,
  parameter int MODE  = MODE_8080,
  parameter int T_SU  = DEF_T_SU,
  parameter int T_PW  = DEF_T_PW,
  parameter int T_HD  = DEF_T_HD,
  parameter int T_REC = DEF_T_REC
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_a0,
  input  logic          req_rd,
  input  logic [DW-1:0] req_wdat,
  output logic          rsp_vld,
  output logic [DW-1:0] rsp_rdat,
  output logic          busy,
  output logic          cs_x,
  output logic          a0,
  output logic          rd_x,
  output logic          wr_x,
  output logic [DW-1:0] dat_o,
  output logic          dat_oe,
  input  logic [DW-1:0] dat_i
);

  localparam int CW = cnt_w(T_SU, T_PW, T_HD, T_REC);
  localparam logic WR_IDLE = (MODE == MODE_6800) ? 1'b0 : 1'b1;

  state_t        r_state;
  logic          r_rdy, r_busy, r_rsp_vld;
  logic          r_cs_x, r_a0, r_rd_x, r_wr_x, r_oe;
  logic          r_rd_l;
  logic [DW-1:0] r_wdat, r_dat_o, r_rdat;

  logic          w_accept, w_zero, w_load;
  logic [CW-1:0] w_lval;

  assign w_accept = req_vld & r_rdy;

  // Counter is reloaded on every phase entry with that phase's length minus one.
  always_comb begin
    w_load = 1'b0;
    w_lval = '0;
    case (r_state)
      ST_IDLE:   if (w_accept) begin w_load = 1'b1; w_lval = CW'(T_SU - 1); end
      ST_SETUP:  if (w_zero)   begin w_load = 1'b1; w_lval = CW'(T_PW - 1); end
      ST_STROBE: if (w_zero)   begin w_load = 1'b1; w_lval = CW'(T_HD - 1); end
      ST_HOLD:   if (w_zero && T_REC > 0) begin w_load = 1'b1; w_lval = CW'(T_REC - 1); end
      default: ;
    endcase
  end

  host_phase_cnt #(.W(CW)) u_phase_cnt (
    .i_clk   (clk),
    .i_rst_x (rst_x),
    .i_load  (w_load),
    .i_val   (w_lval),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state   <= ST_IDLE;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_cs_x    <= 1'b1;
      r_a0      <= 1'b0;
      r_rd_x    <= 1'b1;
      r_wr_x    <= WR_IDLE;
      r_oe      <= 1'b0;
      r_rd_l    <= 1'b0;
      r_wdat    <= '0;
      r_dat_o   <= '0;
      r_rdat    <= '0;
    end else begin
      r_rsp_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_cs_x  <= 1'b0;
            r_a0    <= req_a0;
            r_rd_l  <= req_rd;
            r_wdat  <= req_wdat;
            if (MODE == MODE_6800) r_rd_x <= req_rd;
          end
        end
        ST_SETUP: if (w_zero) begin
          r_state <= ST_STROBE;
          if (MODE == MODE_6800) r_wr_x <= 1'b1;
          else if (r_rd_l)       r_rd_x <= 1'b0;
          else                   r_wr_x <= 1'b0;
          if (!r_rd_l) begin
            r_oe    <= 1'b1;
            r_dat_o <= r_wdat;
          end
        end
        // Read data is captured on the same edge that releases the strobe.
        ST_STROBE: if (w_zero) begin
          r_state <= ST_HOLD;
          if (MODE == MODE_6800) r_wr_x <= 1'b0;
          else begin
            r_rd_x <= 1'b1;
            r_wr_x <= 1'b1;
          end
          if (r_rd_l) begin
            r_rdat    <= dat_i;
            r_rsp_vld <= 1'b1;
          end
        end
        ST_HOLD: if (w_zero) begin
          r_cs_x <= 1'b1;
          r_oe   <= 1'b0;
          if (MODE == MODE_6800) r_rd_x <= 1'b1;
          if (T_REC > 0) r_state <= ST_RECOV;
          else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
          end
        end
        ST_RECOV: if (w_zero) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy  = r_rdy;
  assign busy     = r_busy;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_rdat = r_rdat;
  assign cs_x     = r_cs_x;
  assign a0       = r_a0;
  assign rd_x     = r_rd_x;
  assign wr_x     = r_wr_x;
  assign dat_o    = r_dat_o;
  assign dat_oe   = r_oe;

endmodule

// File: tb/tb_host_bus_master.sv
// Randomised bench for host_bus_master: three configurations checked cycle by
// cycle against a phase-window model of the bus cycle.
module tb_host_bus_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_x;
  logic [2:0]  vld;
  logic        req_a0, req_rd;
  logic [15:0] wdat, dat_i;

  logic [2:0]  rdy, rv, bsy, csx, a0o, rdx, wrx, oe;
  logic [7:0]  a_rdat, a_dato, c_rdat, c_dato;
  logic [15:0] b_rdat, b_dato;

  host_bus_master u_a (
    .clk(clk), .rst_x(rst_x), .req_vld(vld[0]), .req_rdy(rdy[0]), .req_a0(req_a0),
    .req_rd(req_rd), .req_wdat(wdat[7:0]), .rsp_vld(rv[0]), .rsp_rdat(a_rdat),
    .busy(bsy[0]), .cs_x(csx[0]), .a0(a0o[0]), .rd_x(rdx[0]), .wr_x(wrx[0]),
    .dat_o(a_dato), .dat_oe(oe[0]), .dat_i(dat_i[7:0]));

  host_bus_master #(.DW(16), .MODE(1), .T_SU(2), .T_PW(3), .T_HD(2), .T_REC(0)) u_b (
    .clk(clk), .rst_x(rst_x), .req_vld(vld[1]), .req_rdy(rdy[1]), .req_a0(req_a0),
    .req_rd(req_rd), .req_wdat(wdat), .rsp_vld(rv[1]), .rsp_rdat(b_rdat),
    .busy(bsy[1]), .cs_x(csx[1]), .a0(a0o[1]), .rd_x(rdx[1]), .wr_x(wrx[1]),
    .dat_o(b_dato), .dat_oe(oe[1]), .dat_i(dat_i));

  host_bus_master #(.T_SU(1), .T_PW(1), .T_HD(1), .T_REC(0)) u_c (
    .clk(clk), .rst_x(rst_x), .req_vld(vld[2]), .req_rdy(rdy[2]), .req_a0(req_a0),
    .req_rd(req_rd), .req_wdat(wdat[7:0]), .rsp_vld(rv[2]), .rsp_rdat(c_rdat),
    .busy(bsy[2]), .cs_x(csx[2]), .a0(a0o[2]), .rd_x(rdx[2]), .wr_x(wrx[2]),
    .dat_o(c_dato), .dat_oe(oe[2]), .dat_i(dat_i[7:0]));

  // Per-configuration timing table: a, b, c.
  int          su  [3] = '{1, 2, 1};
  int          pw  [3] = '{5, 3, 1};
  int          hd  [3] = '{1, 2, 1};
  int          rec [3] = '{5, 0, 0};
  bit          md  [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] msk [3] = '{16'h00FF, 16'hFFFF, 16'h00FF};
  logic [15:0] last_rd [3];

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  sel;
  logic        m_rdy, m_rv, m_bsy, m_cs, m_a0, m_rd, m_wr, m_oe;
  logic [15:0] m_rdat, m_dato;

  always_comb begin
    m_rdy = rdy[0]; m_rv = rv[0]; m_bsy = bsy[0]; m_cs = csx[0];
    m_a0 = a0o[0]; m_rd = rdx[0]; m_wr = wrx[0]; m_oe = oe[0];
    m_rdat = {8'h00, a_rdat}; m_dato = {8'h00, a_dato};
    case (sel)
      2'd1: begin
        m_rdy = rdy[1]; m_rv = rv[1]; m_bsy = bsy[1]; m_cs = csx[1];
        m_a0 = a0o[1]; m_rd = rdx[1]; m_wr = wrx[1]; m_oe = oe[1];
        m_rdat = b_rdat; m_dato = b_dato;
      end
      2'd2: begin
        m_rdy = rdy[2]; m_rv = rv[2]; m_bsy = bsy[2]; m_cs = csx[2];
        m_a0 = a0o[2]; m_rd = rdx[2]; m_wr = wrx[2]; m_oe = oe[2];
        m_rdat = {8'h00, c_rdat}; m_dato = {8'h00, c_dato};
      end
      default: ;
    endcase
  end

  // One bus transaction on configuration s, checked every cycle from the first
  // SETUP cycle (k=0) through the following IDLE cycle (k=T).
  task automatic txn(input logic [1:0] s, input logic ia0, input logic ird,
                     input logic [15:0] iw, input logic [15:0] ir, input bit hold_vld);
    int SU, PW, HD, T;
    bit st, oe_e, act;
    logic [15:0] w, r;
    logic [6:0]  obs, exp_v;
    SU = su[s]; PW = pw[s]; HD = hd[s]; T = SU + PW + HD + rec[s];
    w = iw & msk[s]; r = ir & msk[s];
    sel = s;
    for (int i = 0; i < 100 && !m_rdy; i++) @(negedge clk);
    n_vec++;
    if (!m_rdy) begin
      n_err++;
      $display("FAIL ready_timeout cfg=%0d got rdy=%b want 1", s, m_rdy);
      return;
    end
    req_a0 = ia0; req_rd = ird; wdat = iw; vld[s] = 1'b1;
    dat_i = 16'($urandom);
    for (int k = 0; k <= T; k++) begin
      @(negedge clk);
      if (k == 0 && !hold_vld) vld[s] = 1'b0;
      st   = (k >= SU) && (k < SU + PW);
      act  = (k < SU + PW + HD);
      oe_e = !ird && (k >= SU) && act;
      if (ird && k == SU + PW) last_rd[s] = r;
      exp_v[6] = (k < T);
      exp_v[5] = (k == T);
      exp_v[4] = !act;
      exp_v[3] = md[s] ? (act ? ird : 1'b1) : !(ird && st);
      exp_v[2] = md[s] ? st : !(!ird && st);
      exp_v[1] = oe_e;
      exp_v[0] = ird && (k == SU + PW);
      obs = {m_bsy, m_rdy, m_cs, m_rd, m_wr, m_oe, m_rv};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL pins cfg=%0d k=%0d {busy,rdy,cs_x,rd_x,wr_x,oe,rsp_vld} got %b want %b",
                 s, k, obs, exp_v);
      end
      n_vec++;
      if (m_rdat !== last_rd[s]) begin
        n_err++;
        $display("FAIL rsp_rdat cfg=%0d k=%0d got %h want %h", s, k, m_rdat, last_rd[s]);
      end
      if (k < T) begin
        n_vec++;
        if (m_a0 !== ia0) begin
          n_err++;
          $display("FAIL a0 cfg=%0d k=%0d got %b want %b", s, k, m_a0, ia0);
        end
      end
      if (oe_e) begin
        n_vec++;
        if (m_dato !== w) begin
          n_err++;
          $display("FAIL dat_o cfg=%0d k=%0d got %h want %h", s, k, m_dato, w);
        end
      end
      dat_i = (k == SU + PW - 1) ? ir : 16'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs, exp_v;
    rst_x = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      last_rd[s] = '0;
      #1;
      obs   = {m_bsy, m_rdy, m_cs, m_a0, m_rd, m_wr, m_oe, m_rv, |m_rdat, |m_dato};
      exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, !md[s], 1'b0, 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_state cfg=%0d got %b want %b", s, obs, exp_v);
      end
    end
    rst_x = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rdy !== 3'b111) begin
      n_err++;
      $display("FAIL rdy_after_reset got %b want 111", rdy);
    end
  endtask

  task automatic test_write_default();
    txn(2'd0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
  endtask

  task automatic test_read_default();
    txn(2'd0, 1'b0, 1'b1, 16'h0000, 16'h00A5, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) txn(2'd0, 1'b0, 1'b0, 16'(i + 1), 16'h0000, 1'b1);
    vld[0] = 1'b0;
  endtask

  task automatic test_mode6800();
    txn(2'd1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0);
    txn(2'd1, 1'b0, 1'b1, 16'h0000, 16'($urandom), 1'b0);
  endtask

  task automatic test_abort();
    logic [5:0] obs;
    sel = 2'd0;
    for (int i = 0; i < 100 && !m_rdy; i++) @(negedge clk);
    req_a0 = 1'b0; req_rd = 1'b1; vld[0] = 1'b1; dat_i = 16'h005A;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (su[0] + 2) @(negedge clk);
    n_vec++;
    if (m_rd !== 1'b0) begin
      n_err++;
      $display("FAIL abort_in_strobe got rd_x=%b want 0", m_rd);
    end
    #2 rst_x = 1'b0;
    #1;
    obs = {m_cs, m_rd, m_oe, m_bsy, m_rv, m_rdy};
    n_vec++;
    if (obs !== 6'b110000) begin
      n_err++;
      $display("FAIL abort_async {cs_x,rd_x,oe,busy,rsp_vld,rdy} got %b want 110000", obs);
    end
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (rv !== 3'b000) begin
        n_err++;
        $display("FAIL abort_rsp_vld got %b want 000", rv);
      end
    end
    rst_x = 1'b1;
    txn(2'd0, 1'b1, 1'b1, 16'h0000, 16'h00C3, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 8; i++)
        txn(2'(s), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
  endtask

  initial begin
    vld = '0; req_a0 = 1'b0; req_rd = 1'b0; wdat = '0; dat_i = '0; sel = 2'd0;
    test_reset();
    test_write_default();
    test_read_default();
    test_back_to_back();
    test_mode6800();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
